// File: rtl/prog_cntr_sel_ctrl.sv
// -----------------------------------------------------------------------------
// prog_cntr_sel_ctrl
//   Sequencer for the fetch-stage PC load mux. Each cycle it picks exactly one
//   PC source (next-sequential, branch target, interrupt vector, return address)
//   and drives the PC load enable and the pipeline flush. It also runs the
//   interrupt request/ack handshake, tracks ISR activity and enforces a
//   post-redirect shadow window during which further redirects are ignored.
//
//   Optional feature macro: PC_SEL_INT_NEST_EN
//     undefined : single in_isr flag, interrupts masked while it is set.
//     defined   : nest counter up to NEST_DEPTH active ISRs.
//
// Parameters
//   FLUSH_CYCLES  shadow-window length after any redirect (1..15)
//   NEST_DEPTH    max ISR nesting depth, nesting build only (1..15)
//
// Ports
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   stall         in   freezes the PC and this controller
//   branch_taken  in   resolved taken branch/jump/call
//   ret_req       in   RET or RETI resolved
//   ret_is_reti   in   qualifies ret_req as RETI
//   int_en        in   global interrupt enable
//   int_req       in   level interrupt request, held until int_ack
//   sel_signals   out  one-hot select: [0] branch [1] next [2] int [3] return
//   pc_load_en    out  PC register load enable
//   flush         out  kill younger fetched/decoded instructions
//   int_ack       out  one-cycle pulse when the interrupt vector is selected
//   in_isr        out  registered, at least one ISR active
// -----------------------------------------------------------------------------
module prog_cntr_sel_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int NEST_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic       ret_req,
  input  logic       ret_is_reti,
  input  logic       int_en,
  input  logic       int_req,
  output logic [3:0] sel_signals,
  output logic       pc_load_en,
  output logic       flush,
  output logic       int_ack,
  output logic       in_isr
);

  localparam logic [3:0] SEL_BRANCH   = 4'b0001;
  localparam logic [3:0] SEL_NEXT     = 4'b0010;
  localparam logic [3:0] SEL_INT      = 4'b0100;
  localparam logic [3:0] SEL_RET      = 4'b1000;
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
      $error("prog_cntr_sel_ctrl: FLUSH_CYCLES must be within 1..15");
    end
    if (NEST_DEPTH < 1 || NEST_DEPTH > 15) begin : g_bad_nest_depth
      $error("prog_cntr_sel_ctrl: NEST_DEPTH must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SHADOW = 2'd2
  } state_t;

  state_t     state, state_d;
  logic [3:0] flush_cnt, flush_cnt_d;
  logic [3:0] last_sel;   // select of the most recent non-stall cycle
  logic [3:0] sel_now;    // select this cycle would drive if not stalled
  logic       int_room;   // ISR tracking allows another interrupt take

`ifdef PC_SEL_INT_NEST_EN
  localparam int NEST_W = $clog2(NEST_DEPTH + 1);
  logic [NEST_W-1:0] nest_cnt, nest_cnt_d;

  assign int_room = (nest_cnt < NEST_W'(NEST_DEPTH));
  assign in_isr   = (nest_cnt != '0);
`else
  logic isr_q, isr_d;

  assign int_room = ~isr_q;
  assign in_isr   = isr_q;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    flush_cnt_d = flush_cnt;
    sel_now     = SEL_NEXT;
    pc_load_en  = 1'b0;
    flush       = 1'b0;
    int_ack     = 1'b0;
`ifdef PC_SEL_INT_NEST_EN
    nest_cnt_d  = nest_cnt;
`else
    isr_d       = isr_q;
`endif

    // A stall leaves every default in place: no load, no flush, no ack, and
    // all state holds.
    if (!stall) begin
      case (state)
        ST_BOOT: begin
          state_d = ST_RUN;
        end

        ST_RUN: begin
          pc_load_en = 1'b1;
          if (ret_req) begin
            sel_now     = SEL_RET;
            flush       = 1'b1;
            state_d     = ST_SHADOW;
            flush_cnt_d = FLUSH_RELOAD;
            // RETI with no active ISR behaves as a plain RET.
            if (ret_is_reti) begin
`ifdef PC_SEL_INT_NEST_EN
              if (nest_cnt != '0) nest_cnt_d = nest_cnt - NEST_W'(1);
`else
              isr_d = 1'b0;
`endif
            end
          end else if (branch_taken) begin
            sel_now     = SEL_BRANCH;
            flush       = 1'b1;
            state_d     = ST_SHADOW;
            flush_cnt_d = FLUSH_RELOAD;
          end else if (int_req && int_en && int_room) begin
            sel_now     = SEL_INT;
            int_ack     = 1'b1;
            flush       = 1'b1;
            state_d     = ST_SHADOW;
            flush_cnt_d = FLUSH_RELOAD;
`ifdef PC_SEL_INT_NEST_EN
            nest_cnt_d  = nest_cnt + NEST_W'(1);
`else
            isr_d       = 1'b1;
`endif
          end
        end

        ST_SHADOW: begin
          // Redirect requests are ignored; fetch simply continues sequentially.
          pc_load_en = 1'b1;
          if (flush_cnt == 4'd0) state_d = ST_RUN;
          else                   flush_cnt_d = flush_cnt - 4'd1;
        end

        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end

    // During a stall the mux keeps pointing where it last pointed, which keeps
    // the select one-hot without disturbing the held PC.
    sel_signals = stall ? last_sel : sel_now;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_BOOT;
      flush_cnt <= 4'd0;
      last_sel  <= SEL_NEXT;
`ifdef PC_SEL_INT_NEST_EN
      nest_cnt  <= '0;
`else
      isr_q     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      flush_cnt <= flush_cnt_d;
      last_sel  <= sel_signals;
`ifdef PC_SEL_INT_NEST_EN
      nest_cnt  <= nest_cnt_d;
`else
      isr_q     <= isr_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_cntr_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_cntr_sel_ctrl
//   Directed scenarios followed by a randomized run, all checked against a
//   cycle-level behavioural model: a boot flag, a count of remaining
//   shadow cycles, an integer ISR depth and the last non-stall select.
//   Build with PC_SEL_INT_NEST_EN defined to exercise nesting (depth 2).
// -----------------------------------------------------------------------------
module tb_prog_cntr_sel_ctrl;

  localparam int FLUSH = 2;
`ifdef PC_SEL_INT_NEST_EN
  localparam int NEST = 2;
  localparam int CAP  = 2;
`else
  localparam int NEST = 4;
  localparam int CAP  = 1;
`endif

  logic       clock;
  logic       reset_n;
  logic       stall, branch_taken, ret_req, ret_is_reti, int_en, int_req;
  logic [3:0] sel_signals;
  logic       pc_load_en, flush, int_ack, in_isr;

  prog_cntr_sel_ctrl #(
    .FLUSH_CYCLES(FLUSH),
    .NEST_DEPTH  (NEST)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .stall       (stall),
    .branch_taken(branch_taken),
    .ret_req     (ret_req),
    .ret_is_reti (ret_is_reti),
    .int_en      (int_en),
    .int_req     (int_req),
    .sel_signals (sel_signals),
    .pc_load_en  (pc_load_en),
    .flush       (flush),
    .int_ack     (int_ack),
    .in_isr      (in_isr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model state
  bit         m_boot;
  int         m_shadow;   // shadow cycles still to run
  int         m_depth;    // active ISRs
  logic [3:0] m_last_sel;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot     = 1'b1;
    m_shadow   = 0;
    m_depth    = 0;
    m_last_sel = 4'b0010;
  endtask

  // Apply inputs right after a falling edge, let the Mealy outputs settle,
  // compare with the model, then advance the model by one cycle.
  task automatic drive(input logic st, input logic br, input logic rt,
                       input logic rti, input logic ie, input logic ir);
    logic [3:0] e_sel;
    logic       e_load, e_flush, e_ack, e_isr;
    stall        = st;
    branch_taken = br;
    ret_req      = rt;
    ret_is_reti  = rti;
    int_en       = ie;
    int_req      = ir;
    #1;
    e_isr   = (m_depth != 0);
    e_sel   = 4'b0010;
    e_load  = 1'b0;
    e_flush = 1'b0;
    e_ack   = 1'b0;
    if (st) begin
      e_sel = m_last_sel;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_shadow > 0) begin
      e_load = 1'b1;
      m_shadow--;
    end else begin
      e_load = 1'b1;
      if (rt) begin
        e_sel = 4'b1000; e_flush = 1'b1; m_shadow = FLUSH;
        if (rti && m_depth > 0) m_depth--;
      end else if (br) begin
        e_sel = 4'b0001; e_flush = 1'b1; m_shadow = FLUSH;
      end else if (ir && ie && m_depth < CAP) begin
        e_sel = 4'b0100; e_flush = 1'b1; e_ack = 1'b1; m_shadow = FLUSH;
        m_depth++;
      end
    end
    if (!st) m_last_sel = e_sel;
    check("sel",    sel_signals, e_sel);
    check("load",   {3'b000, pc_load_en}, {3'b000, e_load});
    check("flush",  {3'b000, flush},      {3'b000, e_flush});
    check("ack",    {3'b000, int_ack},    {3'b000, e_ack});
    check("in_isr", {3'b000, in_isr},     {3'b000, e_isr});
    check("onehot", 4'($countones(sel_signals)), 4'd1);
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic step(input logic st, input logic br, input logic rt,
                      input logic rti, input logic ie, input logic ir);
    drive(st, br, rt, rti, ie, ir);
    tick();
  endtask

  // Assert reset asynchronously mid-cycle and check the reset outputs at once.
  task automatic reset_now(input logic ie, input logic ir);
    reset_n      = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    ret_req      = 1'b0;
    ret_is_reti  = 1'b0;
    int_en       = ie;
    int_req      = ir;
    #1;
    check("rst_sel",    sel_signals, 4'b0010);
    check("rst_load",   {3'b000, pc_load_en}, 4'd0);
    check("rst_flush",  {3'b000, flush},      4'd0);
    check("rst_ack",    {3'b000, int_ack},    4'd0);
    check("rst_in_isr", {3'b000, in_isr},     4'd0);
  endtask

  task automatic release_reset();
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    reset_now(1'b1, 1'b1);
    release_reset();

    // Reset release, no requests: boot cycle then sequential fetch.
    drive(0, 0, 0, 0, 0, 0);
    check("t1_boot_load", {3'b000, pc_load_en}, 4'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t1_run_load", {3'b000, pc_load_en}, 4'd1);
    tick();
    step(0, 0, 0, 0, 0, 0);

    // Branch, then branches inside the shadow window are ignored.
    drive(0, 1, 0, 0, 0, 0);
    check("t2_sel", sel_signals, 4'b0001);
    check("t2_flush", {3'b000, flush}, 4'd1);
    tick();
    for (int i = 0; i < FLUSH; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      check("t2_window_sel", sel_signals, 4'b0010);
      check("t2_window_flush", {3'b000, flush}, 4'd0);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0);
    check("t2_after_window", sel_signals, 4'b0001);
    tick();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

`ifndef PC_SEL_INT_NEST_EN
    // Interrupt take, masking while in ISR.
    drive(0, 0, 0, 0, 1, 1);
    check("t3_ack", {3'b000, int_ack}, 4'd1);
    check("t3_sel", sel_signals, 4'b0100);
    tick();
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    check("t3_in_isr", {3'b000, in_isr}, 4'd1);
    check("t3_masked", {3'b000, int_ack}, 4'd0);
    tick();
    // RETI beats a pending interrupt; the ack follows three cycles later.
    drive(0, 0, 1, 1, 1, 1);
    check("t4_sel", sel_signals, 4'b1000);
    check("t4_noack", {3'b000, int_ack}, 4'd0);
    tick();
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    check("t4_ack_late", {3'b000, int_ack}, 4'd1);
    tick();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // RETI with no active ISR: plain return, no underflow.
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("t_reti_idle_isr", {3'b000, in_isr}, 4'd0);
    tick();
`else
    // Nesting depth 2: two takes, third held off until one RETI.
    drive(0, 0, 0, 0, 1, 1);
    check("n_ack1", {3'b000, int_ack}, 4'd1);
    tick();
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    check("n_ack2", {3'b000, int_ack}, 4'd1);
    tick();
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    check("n_held", {3'b000, int_ack}, 4'd0);
    tick();
    drive(0, 0, 1, 1, 1, 1);
    check("n_reti_sel", sel_signals, 4'b1000);
    tick();
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    check("n_ack3", {3'b000, int_ack}, 4'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
`endif

    // Stall with a pending interrupt: nothing acked until the stall falls.
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, 1);
      check("t5_load", {3'b000, pc_load_en}, 4'd0);
      check("t5_noack", {3'b000, int_ack}, 4'd0);
      check("t5_sel", sel_signals, 4'b0010);
      tick();
    end
    drive(0, 0, 0, 0, 1, 1);
    check("t5_ack", {3'b000, int_ack}, 4'd1);
    tick();

    // Reset in the middle of the shadow window with an active ISR.
    reset_now(1'b1, 1'b1);
    check("t6_rst_in_isr", {3'b000, in_isr}, 4'd0);
    release_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Stall straight after a branch freezes the branch select.
    step(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1);
    check("t5_freeze", sel_signals, 4'b0001);
    tick();
    step(1, 1, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_now(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        release_reset();
      end else begin
        step(1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 6) == 0),
             1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 4) != 0),
             1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
